// File: rtl/sprite_bus_pkg.sv
// Shared types for the sprite-memory bus arbiter: FSM state encoding and a
// width helper used to size owner indices and counters.
package sprite_bus_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so that degenerate counters still get a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sprite_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  localparam logic [IDX_W:0] NUM_V = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so that bit 0 is the requester the pointer currently favours.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = IDX_W'(k);
      end
    end
  end

  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign index = (sum >= NUM_V) ? IDX_W'(sum - NUM_V) : sum[IDX_W-1:0];

endmodule

// File: rtl/sprite_bus_arbiter.sv
// Arbiter for the shared tristate sprite-memory data bus: one-hot output
// enables, guaranteed idle turnaround between owners, round-robin with preemption.
//
// state      | meaning
// IDLE       | nobody owns the bus, pick on any request
// GRANT      | owner drives the bus, hold counter running
// TURNAROUND | all enables low for TA_CYCLES before the next pick
module sprite_bus_arbiter
  import sprite_bus_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_HOLD  = 16,
  parameter int TA_CYCLES = 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        bus_oe,
  output logic [clog2(NUM_REQ)-1:0] owner,
  output logic                      busy,
  output logic                      preempt
);

  localparam int IDX_W  = clog2(NUM_REQ);
  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam int TA_W   = clog2(TA_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TA_W-1:0]   TA_LOAD   = TA_W'(TA_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TA_W-1:0]    ta_cnt;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic               other_wait;
  logic               hold_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign ptr_next     = (owner == IDX_LAST) ? '0 : owner + 1'b1;
  assign other_wait   = |(req & ~grant);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && other_wait;
  assign bus_oe       = grant;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      ta_cnt   <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, TURNAROUND: begin
          if (state == TURNAROUND && ta_cnt != '0) begin
            ta_cnt <= ta_cnt - 1'b1;
          end else if (pick_valid) begin
            grant    <= NUM_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          // A voluntary release wins over preemption, so preempt only flags forced removals.
          if (!req[owner] || hold_expired) begin
            grant   <= '0;
            busy    <= 1'b0;
            rr_ptr  <= ptr_next;
            ta_cnt  <= TA_LOAD;
            preempt <= req[owner];
            state   <= TURNAROUND;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Bench for sprite_bus_arbiter: two instances (turnaround 1 and 3) checked
// against a transaction-level ownership model plus directed trace checks.
module tb_sprite_bus_arbiter;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       resetn_a, resetn_b;
  logic [2:0] req_a, req_b;
  logic [2:0] grant_a, grant_b, bus_oe_a, bus_oe_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, preempt_a, preempt_b;

  int errors = 0;
  int checks = 0;

  sprite_bus_arbiter #(.NUM_REQ(3), .MAX_HOLD(MAXH), .TA_CYCLES(1)) dut_a (
    .clock(clk), .resetn(resetn_a), .req(req_a), .grant(grant_a),
    .bus_oe(bus_oe_a), .owner(owner_a), .busy(busy_a), .preempt(preempt_a));

  sprite_bus_arbiter #(.NUM_REQ(3), .MAX_HOLD(MAXH), .TA_CYCLES(3)) dut_b (
    .clock(clk), .resetn(resetn_b), .req(req_b), .grant(grant_b),
    .bus_oe(bus_oe_b), .owner(owner_b), .busy(busy_b), .preempt(preempt_b));

  initial forever #5 clk = ~clk;

  // Observed vector layout: grant | bus_oe | owner | busy | preempt
  logic [9:0] obs_a, obs_b;
  assign obs_a = {grant_a, bus_oe_a, owner_a, busy_a, preempt_a};
  assign obs_b = {grant_b, bus_oe_b, owner_b, busy_b, preempt_b};

  // Ownership model: who holds the bus, how long, gap cycles left, rr pointer.
  int         m_own[2]  = '{-1, -1};
  int         m_held[2] = '{0, 0};
  int         m_gap[2]  = '{0, 0};
  int         m_ptr[2]  = '{0, 0};
  int         m_last[2] = '{0, 0};
  logic       m_pre[2]  = '{1'b0, 1'b0};
  logic [9:0] exp_v[2]  = '{10'd0, 10'd0};

  task automatic model_step(input int u, input logic [2:0] r, input logic rn, input int tgap);
    logic [2:0] mine;
    m_pre[u] = 1'b0;
    if (!rn) begin
      m_own[u] = -1; m_held[u] = 0; m_gap[u] = 0; m_ptr[u] = 0; m_last[u] = 0;
    end else if (m_own[u] >= 0) begin
      mine = 3'b001 << m_own[u];
      m_held[u]++;
      if ((r & mine) == 3'b000 || (m_held[u] == MAXH && (r & ~mine) != 3'b000)) begin
        m_pre[u] = ((r & mine) != 3'b000);
        m_ptr[u] = (m_own[u] + 1) % 3;
        m_own[u] = -1;
        m_gap[u] = tgap;
      end
    end else begin
      if (m_gap[u] > 0) m_gap[u]--;
      if (m_gap[u] == 0) begin
        for (int i = 0; i < 3; i++) begin
          int j;
          j = (m_ptr[u] + i) % 3;
          if (m_own[u] < 0 && r[j]) begin
            m_own[u] = j; m_last[u] = j; m_held[u] = 0;
          end
        end
      end
    end
    mine = (m_own[u] >= 0) ? (3'b001 << m_own[u]) : 3'b000;
    exp_v[u] = {mine, mine, 2'(m_last[u]), (m_own[u] >= 0), m_pre[u]};
  endtask

  always @(posedge clk) begin
    model_step(0, req_a, resetn_a, 1);
    model_step(1, req_b, resetn_b, 3);
  end

  always @(negedge clk) begin
    assert ($onehot0(grant_a) && $onehot0(grant_b) && bus_oe_a == grant_a && bus_oe_b == grant_b)
      else $error("FAIL onehot0 t=%0t grant_a=%b oe_a=%b grant_b=%b oe_b=%b",
                  $time, grant_a, bus_oe_a, grant_b, bus_oe_b);
  end

  // Trace capture and run-length breakdown for directed ordering checks.
  logic [2:0] trace[$];
  logic [2:0] run_val[$];
  int         run_len[$];

  task automatic make_runs();
    run_val.delete();
    run_len.delete();
    foreach (trace[i]) begin
      if (run_val.size() != 0 && run_val[run_val.size()-1] == trace[i])
        run_len[run_len.size()-1]++;
      else begin
        run_val.push_back(trace[i]);
        run_len.push_back(1);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn_a = 1'b0; resetn_b = 1'b0; req_a = 3'b111; req_b = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (grant_a !== 3'b000 || bus_oe_a !== 3'b000 || busy_a !== 1'b0 || preempt_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got g=%b oe=%b busy=%b pre=%b want all zero",
                 k, grant_a, bus_oe_a, busy_a, preempt_a);
      end
    end
    resetn_a = 1'b1; resetn_b = 1'b1;
    cyc();
    checks++;
    if (grant_a !== 3'b001 || grant_b !== 3'b001) begin
      errors++;
      $display("FAIL reset_release got a=%b b=%b want 001", grant_a, grant_b);
    end
    req_a = 3'b000; req_b = 3'b000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (obs_a !== exp_v[0] || obs_b !== exp_v[1]) begin
        errors++;
        $display("FAIL reset_drain cycle %0d got a=%b b=%b want a=%b b=%b",
                 k, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
  endtask

  task automatic test_single();
    int cnt;
    cnt = 0;
    req_a = 3'b010;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (grant_a == 3'b010) cnt++;
      checks++;
      if (obs_a !== exp_v[0]) begin
        errors++;
        $display("FAIL single_model cycle %0d got %b want %b", k, obs_a, exp_v[0]);
      end
    end
    req_a = 3'b000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (grant_a == 3'b010) cnt++;
    end
    checks++;
    if (cnt != 5) begin
      errors++;
      $display("FAIL single_len got %0d want 5", cnt);
    end
    checks++;
    if (busy_a !== 1'b0 || grant_a !== 3'b000 || owner_a !== 2'd1) begin
      errors++;
      $display("FAIL single_idle got busy=%b g=%b own=%0d want 0 000 1", busy_a, grant_a, owner_a);
    end
  endtask

  task automatic test_round_robin();
    int cnt[3];
    logic [2:0] ord[7];
    ord = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    cnt = '{0, 0, 0};
    resetn_a = 1'b0; cyc(); resetn_a = 1'b1; req_a = 3'b111;
    trace.delete();
    for (int k = 0; k < 30; k++) begin
      cyc();
      trace.push_back(grant_a);
      checks++;
      if (obs_a !== exp_v[0]) begin
        errors++;
        $display("FAIL rr_model cycle %0d got %b want %b", k, obs_a, exp_v[0]);
      end
      for (int i = 0; i < 3; i++) begin
        cnt[i] = grant_a[i] ? cnt[i] + 1 : 0;
        req_a[i] = !(grant_a[i] && cnt[i] >= 4);
      end
    end
    make_runs();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (run_val[i] !== ord[i] || run_len[i] != ((i % 2) ? 1 : 4)) begin
        errors++;
        $display("FAIL rr_order run %0d got %b x%0d want %b x%0d",
                 i, run_val[i], run_len[i], ord[i], (i % 2) ? 1 : 4);
      end
    end
  endtask

  task automatic test_preempt();
    int pulses;
    logic [2:0] ord[5];
    int len[4];
    ord = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
    len = '{16, 1, 16, 1};
    pulses = 0;
    resetn_a = 1'b0; cyc(); resetn_a = 1'b1; req_a = 3'b011;
    trace.delete();
    for (int k = 0; k < 36; k++) begin
      cyc();
      trace.push_back(grant_a);
      if (preempt_a) pulses++;
      checks++;
      if (obs_a !== exp_v[0]) begin
        errors++;
        $display("FAIL preempt_model cycle %0d got %b want %b", k, obs_a, exp_v[0]);
      end
    end
    make_runs();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (run_val[i] !== ord[i] || (i < 4 && run_len[i] != len[i])) begin
        errors++;
        $display("FAIL preempt_order run %0d got %b x%0d want %b", i, run_val[i], run_len[i], ord[i]);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL preempt_pulses got %0d want 2", pulses);
    end
  endtask

  task automatic test_no_contention();
    int held, pulses;
    held = 0; pulses = 0;
    resetn_a = 1'b0; cyc(); resetn_a = 1'b1; req_a = 3'b001;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (grant_a == 3'b001) held++;
      if (preempt_a) pulses++;
      checks++;
      if (obs_a !== exp_v[0]) begin
        errors++;
        $display("FAIL solo_model cycle %0d got %b want %b", k, obs_a, exp_v[0]);
      end
    end
    checks++;
    if (held != 40 || pulses != 0) begin
      errors++;
      $display("FAIL solo_hold got held=%0d pulses=%0d want 40 0", held, pulses);
    end
    req_a = 3'b000;
  endtask

  task automatic test_turnaround_reset();
    int cnt[3];
    int waited;
    logic [2:0] ord[5];
    ord = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    cnt = '{0, 0, 0};
    resetn_b = 1'b0; cyc(); resetn_b = 1'b1; req_b = 3'b111;
    trace.delete();
    for (int k = 0; k < 22; k++) begin
      cyc();
      trace.push_back(grant_b);
      checks++;
      if (obs_b !== exp_v[1]) begin
        errors++;
        $display("FAIL ta_model cycle %0d got %b want %b", k, obs_b, exp_v[1]);
      end
      for (int i = 0; i < 3; i++) begin
        cnt[i] = grant_b[i] ? cnt[i] + 1 : 0;
        req_b[i] = !(grant_b[i] && cnt[i] >= 4);
      end
    end
    make_runs();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (run_val[i] !== ord[i] || run_len[i] != ((i % 2) ? 3 : 4)) begin
        errors++;
        $display("FAIL ta_gap run %0d got %b x%0d want %b x%0d",
                 i, run_val[i], run_len[i], ord[i], (i % 2) ? 3 : 4);
      end
    end
    req_b = 3'b111;
    waited = 0;
    while (grant_b == 3'b000 && waited < 10) begin
      cyc();
      waited++;
    end
    checks++;
    if (grant_b == 3'b000) begin
      errors++;
      $display("FAIL ta_wait_grant got %b want nonzero within 10 cycles", grant_b);
    end
    resetn_b = 1'b0;
    cyc();
    checks++;
    if (bus_oe_b !== 3'b000 || grant_b !== 3'b000 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL ta_midreset got oe=%b g=%b busy=%b want 000 000 0", bus_oe_b, grant_b, busy_b);
    end
    resetn_b = 1'b1;
    cyc();
    checks++;
    if (grant_b !== 3'b001 || obs_b !== exp_v[1]) begin
      errors++;
      $display("FAIL ta_after_reset got %b want %b (grant 001)", obs_b, exp_v[1]);
    end
  endtask

  task automatic test_random();
    resetn_a = 1'b1; resetn_b = 1'b1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) == 0) req_a[i] = ~req_a[i];
        if ($urandom_range(0, 9) == 0) req_b[i] = ~req_b[i];
      end
      resetn_a = ($urandom_range(0, 79) != 0);
      resetn_b = ($urandom_range(0, 79) != 0);
      cyc();
      checks++;
      if (obs_a !== exp_v[0] || obs_b !== exp_v[1]) begin
        errors++;
        $display("FAIL random cycle %0d got a=%b b=%b want a=%b b=%b",
                 k, obs_a, obs_b, exp_v[0], exp_v[1]);
      end
    end
  endtask

  initial begin
    resetn_a = 1'b0; resetn_b = 1'b0; req_a = 3'b000; req_b = 3'b000;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_no_contention();
    test_turnaround_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_bus_arbiter.md
Name: sprite_bus_arbiter

Overview:
Arbitrates the shared tristate sprite-memory data bus between NUM_REQ requesters (e.g. VGA sprite fetch, CPU write port, loader). It produces one-hot output enables that drive the per-requester NBitTristate instances. It inserts bus-idle turnaround cycles between owners so two drivers never overlap. Round-robin fairness applies, with optional forced release after MAX_HOLD cycles.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_HOLD, 16, max consecutive grant cycles while another requester waits; 0 disables preemption
TA_CYCLES, 1, bus-idle cycles between any release and the next grant (min 1)

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
req  input  NUM_REQ  level request; held high while requester wants the bus
grant  output  NUM_REQ  one-hot ownership indication, registered
bus_oe  output  NUM_REQ  one-hot tristate enable to NBitTristate oe, registered, equals grant
owner  output  clog2(NUM_REQ)  index of current/last owner
busy  output  1  high while in GRANT state
preempt  output  1  one-cycle pulse on the edge a grant is forcibly removed by MAX_HOLD

Behaviour:
- Interface fixed: single clock "clock"; reset "resetn" is synchronous, active-low.
- Reset (resetn=0 at an edge): state IDLE; grant=0, bus_oe=0, owner=0, busy=0, preempt=0; rr pointer=0; hold counter=0; TA counter=0. Reset mid-grant drops bus_oe at that edge, with no turnaround.
- States: IDLE, GRANT, TURNAROUND.
- Round-robin pick: first asserted req scanning from the pointer upward, wrapping modulo NUM_REQ.
- IDLE: if any req=1 at edge k, grant/bus_oe for the picked index go high after edge k (1-cycle latency). owner is set to the index, hold counter cleared, state -> GRANT.
- GRANT: hold counter increments each cycle and saturates at MAX_HOLD.
  - Release when req[owner]=0: grant/bus_oe go to 0 at the next edge; pointer = owner+1 mod NUM_REQ; state -> TURNAROUND.
  - Preempt when MAX_HOLD!=0, counter==MAX_HOLD-1, and any other req is high: same transition as release, with preempt pulsed for one cycle. With no other requester waiting, the owner keeps the bus indefinitely.
- TURNAROUND: all bus_oe low for exactly TA_CYCLES cycles. On the edge ending the last TA cycle, perform an IDLE-style pick (grant directly if any req high, else -> IDLE).
- Gap between two different or same-owner grants is always exactly TA_CYCLES cycles when requests are pending.
- The preempted requester's req stays high. It is re-served only after the rr scan reaches it again.
- Invariants: grant and bus_oe are onehot0 every cycle; bus_oe==grant; busy==(state==GRANT); req changes during TURNAROUND affect only the next pick.
- Counters are sized clog2(MAX_HOLD+1) and clog2(TA_CYCLES+1). No arithmetic overflow.

Decomposition:
- Package sprite_bus_pkg holds the state enum (IDLE, GRANT, TURNAROUND) and a clog2 helper function.
- One sub-module, rr_pick: combinational round-robin priority picker (req, pointer -> valid, index).
- FSM, counters and output registers stay in sprite_bus_arbiter.

Test Plan:
- Reset: resetn=0 for 3 edges with req=3'b111 -> grant=0, bus_oe=0, busy=0. Release reset -> grant=3'b001 one edge later.
- Single requester: req=3'b010 for 5 cycles then 0 -> grant=3'b010 for 5 cycles, then 1 idle cycle, state IDLE.
- All requesting, MAX_HOLD=16, each requester drops req after 4 grant cycles and re-raises -> grant order 001,010,100,001. Each grant 4 cycles, separated by exactly 1 all-zero cycle.
- Preemption: req=3'b011 held constantly, MAX_HOLD=16 -> owner 0 held 16 cycles, preempt pulse, 1 idle cycle, owner 1 for 16 cycles, then owner 0.
- No contention: req=3'b001 held 40 cycles, MAX_HOLD=16 -> grant stays 001 for all 40 cycles, preempt never asserts.
- TA_CYCLES=3, reset mid-grant: exactly 3 zero cycles between grants. resetn=0 during GRANT -> bus_oe=0 at that edge. A onehot0 assertion is checked throughout all scenarios.
